ps2_cursor_ctrl: RTL and testbench

PS2_CURSOR_CTRL -- requirements
Module: ps2_cursor_ctrl

---
 rtl/ps2_cursor_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_ps2_cursor_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_cursor_ctrl.sv
// PS/2 keyboard driven board cursor with select / confirm / cancel handshake.
// Arrow keys move the cursor; ENTER selects a source square and later confirms a move.
module ps2_cursor_ctrl #(
    parameter int          X_W     = 3,
    parameter int          Y_W     = 3,
    parameter int          WRAP    = 0,
    parameter int          RST_X   = 0,
    parameter int          RST_Y   = 1,
    parameter logic [7:0]  K_UP    = 8'h1D,
    parameter logic [7:0]  K_DOWN  = 8'h1B,
    parameter logic [7:0]  K_LEFT  = 8'h1C,
    parameter logic [7:0]  K_RIGHT = 8'h23,
    parameter logic [7:0]  K_ENTER = 8'h5A,
    parameter logic [7:0]  K_ESC   = 8'h76
) (
    input  logic                 clk50,
    input  logic                 RST,
    input  logic                 scan_ready,
    input  logic [7:0]           scan_code1,
    input  logic [7:0]           scan_code2,
    input  logic                 piece_under,
    input  logic                 upd_done,
    output logic [X_W-1:0]       x_cursor,
    output logic [Y_W-1:0]       y_cursor,
    output logic [X_W+Y_W-1:0]   cursor,
    output logic                 sel_valid,
    output logic [X_W+Y_W-1:0]   sel_loc,
    output logic                 confirm,
    output logic                 cancel,
    output logic                 busy
);

    localparam int              LOC_W = X_W + Y_W;
    localparam logic [X_W-1:0]  X_MAX = '1;
    localparam logic [Y_W-1:0]  Y_MAX = '1;
    localparam logic [X_W-1:0]  X_ONE = X_W'(1);
    localparam logic [Y_W-1:0]  Y_ONE = Y_W'(1);
    localparam logic [X_W-1:0]  X_RST = X_W'(RST_X);
    localparam logic [Y_W-1:0]  Y_RST = Y_W'(RST_Y);
    localparam logic [7:0]      SC_EXT   = 8'hE0;
    localparam logic [7:0]      SC_BREAK = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECTED,
        S_COMMIT
    } state_e;

    typedef enum logic [2:0] {
        KEY_NONE,
        KEY_UP,
        KEY_DOWN,
        KEY_LEFT,
        KEY_RIGHT,
        KEY_ENTER,
        KEY_ESC
    } key_e;

    state_e            state_q, state_d;
    logic              scan_ready_q, scan_ready_d;
    logic              armed_q, armed_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic              sel_valid_q, sel_valid_d;
    logic [LOC_W-1:0]  sel_loc_q, sel_loc_d;
    logic              confirm_q, confirm_d;
    logic              cancel_q, cancel_d;

    logic              key_evt;
    logic              make_ok;
    logic [7:0]        make_code;
    key_e              key;
    logic [LOC_W-1:0]  cur_loc;

    assign cur_loc = {y_q, x_q};

    // armed_q only rises once scan_ready has been seen low after reset, so a
    // level still held high across reset release never counts as a key event.
    assign scan_ready_d = scan_ready;
    assign armed_d      = armed_q | ~scan_ready;
    assign key_evt      = scan_ready & ~scan_ready_q & armed_q;

    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        make_ok   = 1'b0;
        make_code = scan_code1;
        key       = KEY_NONE;
        if (scan_code1 == SC_BREAK || scan_code2 == SC_BREAK) begin
            make_ok = 1'b0;
        end else if (scan_code1 == SC_EXT) begin
            make_code = scan_code2;
            make_ok   = 1'b1;
        end else begin
            make_ok   = 1'b1;
        end
        // Unknown extended codes fall through the priority chain as KEY_NONE.
        if (key_evt && make_ok) begin
            if      (make_code == K_UP)    key = KEY_UP;
            else if (make_code == K_DOWN)  key = KEY_DOWN;
            else if (make_code == K_LEFT)  key = KEY_LEFT;
            else if (make_code == K_RIGHT) key = KEY_RIGHT;
            else if (make_code == K_ENTER) key = KEY_ENTER;
            else if (make_code == K_ESC)   key = KEY_ESC;
        end
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (state_q != S_COMMIT) begin
            // Natural modular arithmetic supplies the wrap; saturation blocks the edge step.
            unique case (key)
                KEY_UP:    if (WRAP != 0 || y_q != Y_MAX) y_d = y_q + Y_ONE;
                KEY_DOWN:  if (WRAP != 0 || y_q != '0)    y_d = y_q - Y_ONE;
                KEY_RIGHT: if (WRAP != 0 || x_q != X_MAX) x_d = x_q + X_ONE;
                KEY_LEFT:  if (WRAP != 0 || x_q != '0)    x_d = x_q - X_ONE;
                default:   ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_valid_d = sel_valid_q;
        sel_loc_d   = sel_loc_q;
        confirm_d   = 1'b0;
        cancel_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (key == KEY_ENTER && piece_under) begin
                    sel_loc_d   = cur_loc;
                    sel_valid_d = 1'b1;
                    state_d     = S_SELECTED;
                end
            end
            S_SELECTED: begin
                if (key == KEY_ENTER) begin
                    if (cur_loc == sel_loc_q) begin
                        sel_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        confirm_d = 1'b1;
                        state_d   = S_COMMIT;
                    end
                end else if (key == KEY_ESC) begin
                    cancel_d    = 1'b1;
                    sel_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_COMMIT: begin
                if (upd_done) begin
                    sel_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk50 or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            scan_ready_q <= 1'b0;
            armed_q      <= 1'b0;
            x_q          <= X_RST;
            y_q          <= Y_RST;
            sel_valid_q  <= 1'b0;
            sel_loc_q    <= '0;
            confirm_q    <= 1'b0;
            cancel_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            scan_ready_q <= scan_ready_d;
            armed_q      <= armed_d;
            x_q          <= x_d;
            y_q          <= y_d;
            sel_valid_q  <= sel_valid_d;
            sel_loc_q    <= sel_loc_d;
            confirm_q    <= confirm_d;
            cancel_q     <= cancel_d;
        end
    end

    assign x_cursor  = x_q;
    assign y_cursor  = y_q;
    assign cursor    = cur_loc;
    assign sel_valid = sel_valid_q;
    assign sel_loc   = sel_loc_q;
    assign confirm   = confirm_q;
    assign cancel    = cancel_q;
    assign busy      = (state_q == S_COMMIT);

endmodule

// File: tb/tb_ps2_cursor_ctrl.sv
// Bench for ps2_cursor_ctrl: a saturating and a wrapping instance share one stimulus stream.
// Cursor vectors go through a scoreboard queue; selection/commit corners are hand sequences.
module tb_ps2_cursor_ctrl;

    logic       clk50 = 1'b0;
    logic       RST;
    logic       scan_ready;
    logic [7:0] scan_code1, scan_code2;
    logic       piece_under, upd_done;

    logic [2:0] x0, y0, x1, y1;
    logic [5:0] cur0, cur1, loc0, loc1;
    logic       sv0, sv1, conf0, conf1, canc0, canc1, busy0, busy1;

    int checks = 0;
    int errors = 0;
    int conf_cnt = 0;
    int canc_cnt = 0;
    int overlap_cnt = 0;

    always #10 clk50 = ~clk50;

    ps2_cursor_ctrl #(.WRAP(0)) d0 (
        .clk50(clk50), .RST(RST), .scan_ready(scan_ready),
        .scan_code1(scan_code1), .scan_code2(scan_code2),
        .piece_under(piece_under), .upd_done(upd_done),
        .x_cursor(x0), .y_cursor(y0), .cursor(cur0),
        .sel_valid(sv0), .sel_loc(loc0),
        .confirm(conf0), .cancel(canc0), .busy(busy0)
    );

    ps2_cursor_ctrl #(.WRAP(1)) d1 (
        .clk50(clk50), .RST(RST), .scan_ready(scan_ready),
        .scan_code1(scan_code1), .scan_code2(scan_code2),
        .piece_under(piece_under), .upd_done(upd_done),
        .x_cursor(x1), .y_cursor(y1), .cursor(cur1),
        .sel_valid(sv1), .sel_loc(loc1),
        .confirm(conf1), .cancel(canc1), .busy(busy1)
    );

    // Pulse monitor for the saturating instance.
    always @(negedge clk50) begin
        if (conf0) conf_cnt++;
        if (canc0) canc_cnt++;
        if (conf0 && canc0) overlap_cnt++;
    end

    typedef struct {
        logic [7:0] c1;
        logic [7:0] c2;
        logic [2:0] x0;
        logic [2:0] y0;
        logic [2:0] x1;
        logic [2:0] y1;
    } vec_t;

    typedef struct {
        logic [2:0] x0;
        logic [2:0] y0;
        logic [2:0] x1;
        logic [2:0] y1;
    } exp_t;

    vec_t vecs[18];
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_key(input logic [7:0] c1, input logic [7:0] c2);
        @(negedge clk50);
        scan_code1 = c1;
        scan_code2 = c2;
        scan_ready = 1'b1;
        @(negedge clk50);
        scan_ready = 1'b0;
        @(negedge clk50);
        @(negedge clk50);
    endtask

    task automatic do_reset();
        @(negedge clk50);
        RST = 1'b0;
        scan_ready = 1'b0;
        repeat (3) @(negedge clk50);
        RST = 1'b1;
        repeat (2) @(negedge clk50);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, k0;
        exp_t e;

        // {scan_code1, scan_code2, x0, y0, x1, y1} -- instance 0 saturates, instance 1 wraps.
        vecs[0]  = '{8'h1D, 8'h00, 3'd0, 3'd2, 3'd0, 3'd2};
        vecs[1]  = '{8'h1D, 8'h00, 3'd0, 3'd3, 3'd0, 3'd3};
        vecs[2]  = '{8'h1D, 8'h00, 3'd0, 3'd4, 3'd0, 3'd4};
        vecs[3]  = '{8'h1D, 8'h00, 3'd0, 3'd5, 3'd0, 3'd5};
        vecs[4]  = '{8'h1D, 8'h00, 3'd0, 3'd6, 3'd0, 3'd6};
        vecs[5]  = '{8'h1D, 8'h00, 3'd0, 3'd7, 3'd0, 3'd7};
        vecs[6]  = '{8'h1D, 8'h00, 3'd0, 3'd7, 3'd0, 3'd0};
        vecs[7]  = '{8'h1B, 8'h00, 3'd0, 3'd6, 3'd0, 3'd7};
        vecs[8]  = '{8'hF0, 8'h1D, 3'd0, 3'd6, 3'd0, 3'd7};
        vecs[9]  = '{8'h1D, 8'hF0, 3'd0, 3'd6, 3'd0, 3'd7};
        vecs[10] = '{8'hE0, 8'h1D, 3'd0, 3'd7, 3'd0, 3'd0};
        vecs[11] = '{8'hE0, 8'h55, 3'd0, 3'd7, 3'd0, 3'd0};
        vecs[12] = '{8'h55, 8'h00, 3'd0, 3'd7, 3'd0, 3'd0};
        vecs[13] = '{8'h1C, 8'h00, 3'd0, 3'd7, 3'd7, 3'd0};
        vecs[14] = '{8'h23, 8'h00, 3'd1, 3'd7, 3'd0, 3'd0};
        vecs[15] = '{8'hE0, 8'h1C, 3'd0, 3'd7, 3'd7, 3'd0};
        vecs[16] = '{8'hE0, 8'hF0, 3'd0, 3'd7, 3'd7, 3'd0};
        vecs[17] = '{8'h1B, 8'h00, 3'd0, 3'd6, 3'd7, 3'd7};

        RST = 1'b0;
        scan_ready = 1'b0;
        scan_code1 = 8'h00;
        scan_code2 = 8'h00;
        piece_under = 1'b0;
        upd_done = 1'b0;
        repeat (3) @(negedge clk50);

        check("rst_x", x0, 0);
        check("rst_y", y0, 1);
        check("rst_cursor", cur0, 6'h08);
        check("rst_sel_valid", sv0, 0);
        check("rst_sel_loc", loc0, 0);
        check("rst_busy", busy0, 0);
        check("rst_confirm", conf0, 0);
        check("rst_cancel", canc0, 0);
        RST = 1'b1;
        repeat (2) @(negedge clk50);

        foreach (vecs[i]) begin
            sb_q.push_back('{vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1});
            send_key(vecs[i].c1, vecs[i].c2);
            e = sb_q.pop_front();
            check($sformatf("vec%0d_x_sat", i), x0, e.x0);
            check($sformatf("vec%0d_y_sat", i), y0, e.y0);
            check($sformatf("vec%0d_x_wrap", i), x1, e.x1);
            check($sformatf("vec%0d_y_wrap", i), y1, e.y1);
        end
        check("vec_sel_idle", sv0, 0);

        // Select, move, confirm, commit.
        do_reset();
        piece_under = 1'b1;
        send_key(8'h5A, 8'h00);
        check("sel_valid_set", sv0, 1);
        check("sel_loc_latch", loc0, 6'h08);
        check("sel_not_busy", busy0, 0);
        c0 = conf_cnt;
        send_key(8'h23, 8'h00);
        check("sel_move_x", x0, 1);
        check("sel_move_keeps_valid", sv0, 1);
        send_key(8'h5A, 8'h00);
        check("confirm_one_cycle", conf_cnt - c0, 1);
        check("commit_busy", busy0, 1);
        check("commit_sel_valid", sv0, 1);
        send_key(8'h1D, 8'h00);
        check("commit_arrow_y", y0, 1);
        check("commit_arrow_x", x0, 1);
        check("commit_still_busy", busy0, 1);
        check("commit_no_reconfirm", conf_cnt - c0, 1);
        @(negedge clk50);
        upd_done = 1'b1;
        @(negedge clk50);
        upd_done = 1'b0;
        check("upd_busy_clear", busy0, 0);
        check("upd_sel_clear", sv0, 0);
        @(negedge clk50);
        upd_done = 1'b1;
        @(negedge clk50);
        upd_done = 1'b0;
        check("upd_idle_ignored_busy", busy0, 0);
        check("upd_idle_ignored_sel", sv0, 0);

        // Select then cancel with ESC.
        k0 = canc_cnt;
        send_key(8'h5A, 8'h00);
        check("sel2_loc", loc0, 6'h09);
        send_key(8'h76, 8'h00);
        check("cancel_one_cycle", canc_cnt - k0, 1);
        check("cancel_sel_clear", sv0, 0);

        // ENTER without a piece, then select and deselect on the same square.
        piece_under = 1'b0;
        send_key(8'h5A, 8'h00);
        check("enter_no_piece", sv0, 0);
        piece_under = 1'b1;
        c0 = conf_cnt;
        k0 = canc_cnt;
        send_key(8'h5A, 8'h00);
        check("sel3_valid", sv0, 1);
        send_key(8'h5A, 8'h00);
        check("deselect_sel", sv0, 0);
        check("deselect_busy", busy0, 0);
        check("deselect_no_confirm", conf_cnt - c0, 0);
        check("deselect_no_cancel", canc_cnt - k0, 0);
        send_key(8'h76, 8'h00);
        check("esc_idle_no_cancel", canc_cnt - k0, 0);

        // scan_ready held high: a single event.
        @(negedge clk50);
        scan_code1 = 8'h1D;
        scan_code2 = 8'h00;
        scan_ready = 1'b1;
        repeat (100) @(negedge clk50);
        scan_ready = 1'b0;
        repeat (2) @(negedge clk50);
        check("held_ready_one_step", y0, 2);

        // Reset during COMMIT.
        send_key(8'h5A, 8'h00);
        send_key(8'h1C, 8'h00);
        c0 = conf_cnt;
        send_key(8'h5A, 8'h00);
        check("pre_rst_commit", busy0, 1);
        check("pre_rst_confirm", conf_cnt - c0, 1);
        @(negedge clk50);
        RST = 1'b0;
        #1;
        check("midrst_x", x0, 0);
        check("midrst_y", y0, 1);
        check("midrst_sel_valid", sv0, 0);
        check("midrst_sel_loc", loc0, 0);
        check("midrst_busy", busy0, 0);
        check("midrst_confirm", conf0, 0);
        check("midrst_cancel", canc0, 0);
        scan_code1 = 8'h1D;
        scan_code2 = 8'h00;
        scan_ready = 1'b1;
        repeat (3) @(negedge clk50);
        RST = 1'b1;
        repeat (5) @(negedge clk50);
        check("postrst_held_ready_no_event", y0, 1);
        check("postrst_no_confirm", conf_cnt - c0, 1);
        check("postrst_busy", busy0, 0);
        scan_ready = 1'b0;
        repeat (2) @(negedge clk50);
        send_key(8'h1D, 8'h00);
        check("postrst_fresh_edge", y0, 2);
        check("no_confirm_cancel_overlap", overlap_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
